csr_regfile: RTL and testbench

//  Machine-mode CSR file; the responder to the decoder's CSR read interface (csr_en/csr_idx -> csr_rdata).

---
 rtl/csr_if.sv | 23 ++
 rtl/csr_regfile.sv | 171 +++++++++++++++++
 tb/tb_csr_regfile.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_if.sv
// CSR access channel between the instruction decoder (master) and the CSR file (slave).
// Read data and the illegal flag are combinational responses within the same cycle.
interface csr_if #(
    parameter int XLEN = 64
);
    logic            csr_en;
    logic [11:0]     csr_idx;
    logic [5:0]      csr_info;
    logic [XLEN-1:0] csr_src;
    logic [4:0]      csr_zimm;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_ilegl;

    modport master (
        output csr_en, csr_idx, csr_info, csr_src, csr_zimm,
        input  csr_rdata, csr_ilegl
    );

    modport slave (
        input  csr_en, csr_idx, csr_info, csr_src, csr_zimm,
        output csr_rdata, csr_ilegl
    );
endinterface

// File: rtl/csr_regfile.sv
// Machine-mode CSR file for a single-cycle RV64 core: Zicsr read-modify-write, trap entry,
// mret and the mcycle/minstret counters. Reads and redirect are combinational.
module csr_regfile #(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = 64'h0000_0000_8000_0000,
    parameter logic [XLEN-1:0] HART_ID     = '0,
    parameter logic [XLEN-1:0] MISA_VAL    = 64'h8000_0000_0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    csr_if.slave            csr,
    input  logic            ecall_i,
    input  logic            ebreak_i,
    input  logic            mret_i,
    input  logic            ilegl_instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    input  logic            retire_i,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o
);
    localparam logic [XLEN-1:0] MIE_MASK = XLEN'(12'h888);

    logic            mst_mie_q,  mst_mie_d;
    logic            mst_mpie_q, mst_mpie_d;
    logic [XLEN-1:0] mie_q,      mie_d;
    logic [XLEN-1:0] mtvec_q,    mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q,     mepc_d;
    logic [XLEN-1:0] mcause_q,   mcause_d;
    logic [XLEN-1:0] mtval_q,    mtval_d;
    logic [XLEN-1:0] mcycle_q,   mcycle_d;
    logic [XLEN-1:0] minstret_q, minstret_d;

    logic            imm_form, set_form, clr_form, wr_attempt, implemented;
    logic            csr_wr, trap, illegal_trap;
    logic [XLEN-1:0] operand, old_val, new_val, mstatus_rd, cause, tval;

    // Decode, old-value mux and the read-modify-write result
    always_comb begin
        imm_form   = |csr.csr_info[2:0];
        set_form   = csr.csr_info[4] | csr.csr_info[1];
        clr_form   = csr.csr_info[3] | csr.csr_info[0];
        operand    = imm_form ? {{(XLEN-5){1'b0}}, csr.csr_zimm} : csr.csr_src;
        // Set/clear forms with rs1=x0 (or zimm=0) are pure reads.
        wr_attempt = csr.csr_info[5] | csr.csr_info[2]
                   | ((set_form | clr_form) & (csr.csr_zimm != 5'd0));

        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mst_mpie_q;
        mstatus_rd[3]     = mst_mie_q;

        implemented = 1'b1;
        old_val     = '0;
        case (csr.csr_idx)
            12'h300: old_val = mstatus_rd;
            12'h301: old_val = MISA_VAL;
            12'h304: old_val = mie_q;
            12'h305: old_val = mtvec_q;
            12'h340: old_val = mscratch_q;
            12'h341: old_val = mepc_q;
            12'h342: old_val = mcause_q;
            12'h343: old_val = mtval_q;
            12'h344: old_val = '0;
            12'hB00: old_val = mcycle_q;
            12'hB02: old_val = minstret_q;
            12'hC00: old_val = mcycle_q;
            12'hC02: old_val = minstret_q;
            12'hF14: old_val = HART_ID;
            default: implemented = 1'b0;
        endcase

        if (set_form)      new_val = old_val | operand;
        else if (clr_form) new_val = old_val & ~operand;
        else               new_val = operand;

        csr.csr_ilegl = csr.csr_en
                      & (~implemented | (wr_attempt & (csr.csr_idx[11:10] == 2'b11)));
        csr.csr_rdata = csr.csr_en ? old_val : '0;

        illegal_trap = ilegl_instr_i | csr.csr_ilegl;
        trap         = illegal_trap | ebreak_i | ecall_i;
        if (illegal_trap) begin
            cause = XLEN'(2);
            tval  = {{(XLEN-32){1'b0}}, instr_i};
        end else if (ebreak_i) begin
            cause = XLEN'(3);
            tval  = pc_i;
        end else begin
            cause = XLEN'(11);
            tval  = '0;
        end

        csr_wr = csr.csr_en & wr_attempt & ~csr.csr_ilegl & ~trap;

        redirect_o    = trap | mret_i;
        redirect_pc_o = trap ? mtvec_q : (mret_i ? mepc_q : '0);
    end

    // Next state: later assignments take priority (trap > mret > write > increment)
    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + XLEN'(1);
        minstret_d = minstret_q + XLEN'(retire_i & ~trap);

        if (csr_wr) begin
            case (csr.csr_idx)
                12'h300: begin
                    mst_mie_d  = new_val[3];
                    mst_mpie_d = new_val[7];
                end
                12'h304: mie_d      = new_val & MIE_MASK;
                12'h305: mtvec_d    = {new_val[XLEN-1:2], 2'b00};
                12'h340: mscratch_d = new_val;
                12'h341: mepc_d     = {new_val[XLEN-1:2], 2'b00};
                12'h342: mcause_d   = new_val;
                12'h343: mtval_d    = new_val;
                12'hB00: mcycle_d   = new_val;
                12'hB02: minstret_d = new_val;
                default: ;
            endcase
        end

        if (mret_i && !trap) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end

        if (trap) begin
            mepc_d     = pc_i;
            mcause_d   = cause;
            mtval_d    = tval;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
endmodule

// File: tb/tb_csr_regfile.sv
// Scoreboard bench for csr_regfile: each stimulus cycle queues its expected outputs,
// which are popped and compared on the following falling edge.
module tb_csr_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        ecall, ebreak, mret, ilegl_instr, retire;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        redirect;
    logic [63:0] redirect_pc;

    always #5 clk = ~clk;

    csr_if #(.XLEN(64)) bus ();

    csr_regfile dut (
        .clk           (clk),
        .rst           (rst),
        .csr           (bus),
        .ecall_i       (ecall),
        .ebreak_i      (ebreak),
        .mret_i        (mret),
        .ilegl_instr_i (ilegl_instr),
        .pc_i          (pc),
        .instr_i       (instr),
        .retire_i      (retire),
        .redirect_o    (redirect),
        .redirect_pc_o (redirect_pc)
    );

    localparam logic [5:0] RW = 6'b100000, RS = 6'b010000, RC = 6'b001000;
    localparam logic [5:0] RSI = 6'b000010;
    localparam int SEL_RDATA = 0, SEL_ILEGL = 1, SEL_REDIR = 2, SEL_RPC = 3;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
        end else begin
            $display("ok   %s got=0x%h", tag, got);
        end
    endtask

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            SEL_RDATA: return bus.csr_rdata;
            SEL_ILEGL: return {63'd0, bus.csr_ilegl};
            SEL_REDIR: return {63'd0, redirect};
            default:   return redirect_pc;
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sel, input logic [63:0] exp);
        sb_q.push_back('{tag, sel, exp});
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.csr_en   = 1'b0;
        bus.csr_idx  = 12'h000;
        bus.csr_info = 6'b000000;
        bus.csr_src  = 64'd0;
        bus.csr_zimm = 5'd0;
        ecall = 1'b0; ebreak = 1'b0; mret = 1'b0; ilegl_instr = 1'b0; retire = 1'b0;
        pc = 64'd0; instr = 32'd0;
    endtask

    task automatic set_csr(input logic [11:0] idx, input logic [5:0] info,
                           input logic [63:0] src, input logic [4:0] zimm);
        clr();
        bus.csr_en   = 1'b1;
        bus.csr_idx  = idx;
        bus.csr_info = info;
        bus.csr_src  = src;
        bus.csr_zimm = zimm;
    endtask

    task automatic wr(input logic [11:0] idx, input logic [5:0] info,
                      input logic [63:0] src, input logic [4:0] zimm);
        set_csr(idx, info, src, zimm);
        tick();
    endtask

    task automatic op(input string tag, input logic [11:0] idx, input logic [5:0] info,
                      input logic [63:0] src, input logic [4:0] zimm, input logic [63:0] exp);
        set_csr(idx, info, src, zimm);
        expect_out(tag, SEL_RDATA, exp);
        tick();
    endtask

    task automatic rd(input string tag, input logic [11:0] idx, input logic [63:0] exp);
        op(tag, idx, RS, 64'd0, 5'd0, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        rd("rst_mtvec", 12'h305, 64'h8000_0000);
        rd("rst_mstatus", 12'h300, 64'h1800);
        rd("rst_mhartid", 12'hF14, 64'd0);
        rd("rst_misa", 12'h301, 64'h8000_0000_0000_0100);
        clr(); bus.csr_idx = 12'h305;
        expect_out("rd_disabled", SEL_RDATA, 64'd0);
        tick();

        // Read-modify-write on mscratch
        op("rw340_old", 12'h340, RW, 64'hDEAD, 5'd1, 64'd0);
        op("rs340_old", 12'h340, RS, 64'h0F00, 5'd1, 64'hDEAD);
        op("rc340_x0", 12'h340, RC, '1, 5'd0, 64'hDFAD);
        rd("mscratch_keep", 12'h340, 64'hDFAD);

        // WARL masks
        wr(12'h305, RW, 64'h1003, 5'd1);
        rd("mtvec_warl", 12'h305, 64'h1000);
        wr(12'h304, RW, '1, 5'd1);
        rd("mie_warl", 12'h304, 64'h888);
        wr(12'h344, RW, '1, 5'd1);
        rd("mip_zero", 12'h344, 64'd0);
        wr(12'h341, RW, 64'h203, 5'd1);
        rd("mepc_warl", 12'h341, 64'h200);
        wr(12'h300, RW, '1, 5'd1);
        rd("mstatus_warl", 12'h300, 64'h1888);
        wr(12'h300, RC, 64'h80, 5'd1);
        rd("mstatus_rc", 12'h300, 64'h1808);

        // ecall trap
        clr(); ecall = 1'b1; pc = 64'h100;
        expect_out("ecall_redir", SEL_REDIR, 64'd1);
        expect_out("ecall_rpc", SEL_RPC, 64'h1000);
        tick();
        rd("ecall_mepc", 12'h341, 64'h100);
        rd("ecall_mcause", 12'h342, 64'd11);
        rd("ecall_mtval", 12'h343, 64'd0);
        rd("ecall_mstatus", 12'h300, 64'h1880);

        // mret
        clr(); mret = 1'b1;
        expect_out("mret_redir", SEL_REDIR, 64'd1);
        expect_out("mret_rpc", SEL_RPC, 64'h100);
        tick();
        rd("mret_mstatus", 12'h300, 64'h1888);
        clr();
        expect_out("idle_redir", SEL_REDIR, 64'd0);
        expect_out("idle_rpc", SEL_RPC, 64'd0);
        tick();

        // Write to read-only counter shadow is illegal and must not modify state
        set_csr(12'hC00, RW, 64'd1, 5'd1); instr = 32'hC000_1073; pc = 64'h300;
        expect_out("c00w_ilegl", SEL_ILEGL, 64'd1);
        expect_out("c00w_redir", SEL_REDIR, 64'd1);
        expect_out("c00w_rpc", SEL_RPC, 64'h1000);
        tick();
        rd("c00w_mcause", 12'h342, 64'd2);
        rd("c00w_mtval", 12'h343, 64'hC000_1073);
        rd("c00w_mepc", 12'h341, 64'h300);
        set_csr(12'hC00, RSI, 64'd0, 5'd0);
        expect_out("c00r_legal", SEL_ILEGL, 64'd0);
        tick();
        set_csr(12'h7C0, RS, 64'd0, 5'd0); instr = 32'h7C00_2073;
        expect_out("7c0_ilegl", SEL_ILEGL, 64'd1);
        expect_out("7c0_rdata", SEL_RDATA, 64'd0);
        tick();
        rd("7c0_mtval", 12'h343, 64'h7C00_2073);
        set_csr(12'h340, RW, 64'h1234, 5'd1); ecall = 1'b1;
        tick();
        rd("trap_no_wr", 12'h340, 64'hDFAD);

        // Counter wrap and write-over-increment
        wr(12'hB00, RW, '1, 5'd1);
        rd("mcycle_max", 12'hB00, '1);
        rd("mcycle_wrap", 12'hB00, 64'd0);
        wr(12'hB00, RW, 64'd5, 5'd1);
        rd("mcycle_wr", 12'hB00, 64'd5);
        rd("cycle_inc", 12'hC00, 64'd6);

        // minstret suppressed by trap; ebreak cause and tval
        rd("minstret0", 12'hB02, 64'd0);
        clr(); ebreak = 1'b1; retire = 1'b1; pc = 64'h400;
        expect_out("ebreak_redir", SEL_REDIR, 64'd1);
        tick();
        rd("ebreak_minstret", 12'hB02, 64'd0);
        rd("ebreak_mcause", 12'h342, 64'd3);
        rd("ebreak_mtval", 12'h343, 64'h400);
        clr(); retire = 1'b1;
        tick();
        rd("retire_minstret", 12'hC02, 64'd1);

        // Cause priority
        clr(); ecall = 1'b1; ebreak = 1'b1; pc = 64'h500;
        tick();
        rd("prio_ebreak", 12'h342, 64'd3);
        clr(); ilegl_instr = 1'b1; ebreak = 1'b1; instr = 32'hFFFF_FFFF; pc = 64'h600;
        tick();
        rd("prio_ilegl", 12'h342, 64'd2);
        rd("prio_mtval", 12'h343, 64'hFFFF_FFFF);

        // Reset mid-sequence
        wr(12'h340, RW, 64'h55, 5'd1);
        clr(); rst = 1'b1;
        tick();
        rst = 1'b0;
        rd("rst2_mscratch", 12'h340, 64'd0);
        rd("rst2_mtvec", 12'h305, 64'h8000_0000);
        rd("rst2_mstatus", 12'h300, 64'h1800);
        rd("rst2_minstret", 12'hB02, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
